// File: rtl/mcu_pkg.sv
// mcu_pkg: shared definitions for the convolution memory-bank controller.
//   mode_e  : operating mode decoded from the {eop, sop} framing bits
//   clog2   : ceiling log2, usable in constant (parameter) expressions
//   bw_of   : index width for an N-entry ring, never narrower than 1 bit
package mcu_pkg;

    typedef enum logic [1:0] {
        MODE_LOAD    = 2'd0,
        MODE_PROC    = 2'd1,
        MODE_OUT     = 2'd2,
        MODE_ILLEGAL = 2'd3
    } mode_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int bw_of(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/mcu_bank_ctrl_if.sv
// mcu_bank_ctrl_if: framing inputs and bank-control outputs of mcu_bank_ctrl.
//   i_sop, i_eop : mode bits ({eop,sop}: 00 LOAD, 01 PROC, 10 OUT, 11 illegal)
//   i_chblk      : block-change strobe (level; rising edge is the event)
//   o_we         : per-bank write enable
//   o_mem_sel    : selected bank index
//   o_win_base   : first bank of the PROC window
//   o_state      : registered mode
//   o_substate   : addressing substate
//   o_blk_cnt    : blocks loaded since last PROC entry (saturating)
//   o_ready      : enough blocks loaded for a kernel window
//   o_err        : sticky illegal-mode flag
// Modports: master drives the framing inputs, slave is the controller.
interface mcu_bank_ctrl_if
    import mcu_pkg::*;
#(
    parameter int NB_BANK = 5,
    parameter int SUB     = 2
);
    localparam int BW = bw_of(NB_BANK);
    localparam int SW = bw_of(SUB);
    localparam int CW = clog2(NB_BANK + 1);

    logic               i_sop;
    logic               i_eop;
    logic               i_chblk;
    logic [NB_BANK-1:0] o_we;
    logic [BW-1:0]      o_mem_sel;
    logic [BW-1:0]      o_win_base;
    logic [1:0]         o_state;
    logic [SW-1:0]      o_substate;
    logic [CW-1:0]      o_blk_cnt;
    logic               o_ready;
    logic               o_err;

    modport master (
        output i_sop, i_eop, i_chblk,
        input  o_we, o_mem_sel, o_win_base, o_state, o_substate,
               o_blk_cnt, o_ready, o_err
    );

    modport slave (
        input  i_sop, i_eop, i_chblk,
        output o_we, o_mem_sel, o_win_base, o_state, o_substate,
               o_blk_cnt, o_ready, o_err
    );

endinterface

// File: rtl/mcu_ring_ptr.sv
// mcu_ring_ptr: modulo-N index counter.
//   clk, rst : clock, synchronous active-high reset (idx=0, onehot=bit0)
//   en       : advance by step on this edge
//   step     : advance amount, 0..N (one bit wider than idx)
//   idx      : current index, 0..N-1
//   onehot   : registered one-hot decode of idx
module mcu_ring_ptr #(
    parameter int N = 5,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W:0]   step,
    output logic [W-1:0] idx,
    output logic [N-1:0] onehot
);

    logic [W:0]   sum;
    logic [W-1:0] idx_nxt;

    // The sum is formed one bit wider than the index so a power-of-two N
    // cannot overflow before the wrap compare.
    always_comb begin
        sum = {1'b0, idx} + step;
        if (sum >= (W+1)'(N)) begin
            idx_nxt = W'(sum - (W+1)'(N));
        end else begin
            idx_nxt = W'(sum);
        end
    end

    // Register stage: index and its one-hot image move together.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx    <= '0;
            onehot <= N'(1);
        end else if (en) begin
            idx    <= idx_nxt;
            onehot <= N'(1) << idx_nxt;
        end
    end

endmodule

// File: rtl/mcu_bank_ctrl.sv
// mcu_bank_ctrl: bank ring controller for the 2D convolution datapath.
// A ring of NB_KER + NB_SPARE line-buffer banks is loaded one bank per
// block, read NB_KER banks at a time in PROC, and drained in OUT.
//   clk : clock
//   rst : synchronous active-high reset
//   bus : mcu_bank_ctrl_if.slave (framing inputs, bank-control outputs)
// All outputs are derived from registered state: one cycle from inputs.
module mcu_bank_ctrl
    import mcu_pkg::*;
#(
    parameter int NB_KER   = 3,
    parameter int NB_SPARE = 2,
    parameter int STRIDE   = 2,
    parameter int SUB      = NB_KER / 2 + 1
) (
    input  logic           clk,
    input  logic           rst,
    mcu_bank_ctrl_if.slave bus
);

    localparam int NB_BANK = NB_KER + NB_SPARE;
    localparam int BW      = bw_of(NB_BANK);
    localparam int SW      = bw_of(SUB);
    localparam int CW      = clog2(NB_BANK + 1);

    mode_e              state, state_nxt, prev_state;
    logic               chblk_d;
    logic               entry, chblk_evt;
    logic               load_en, out_en, win_en;
    logic [BW-1:0]      load_idx, out_idx, win_base;
    logic [NB_BANK-1:0] load_oh;
    logic [NB_BANK-1:0] unused_out_oh, unused_win_oh;
    logic [SW-1:0]      substate;
    logic [CW-1:0]      blk_cnt;
    logic               err;
    logic [NB_BANK-1:0] we;
    logic [BW-1:0]      mem_sel;

    // NB_KER contiguous banks from base, wrapping round the ring. NB_KER is
    // strictly less than NB_BANK, so one subtraction completes the wrap.
    function automatic logic [NB_BANK-1:0] proc_mask(input logic [BW-1:0] base);
        logic [NB_BANK-1:0] m;
        logic [BW:0]        p;
        m = '0;
        for (int k = 0; k < NB_KER; k++) begin
            p = {1'b0, base} + (BW+1)'(k);
            if (p >= (BW+1)'(NB_BANK)) p = p - (BW+1)'(NB_BANK);
            m[p[BW-1:0]] = 1'b1;
        end
        return m;
    endfunction

    // A chblk edge landing on the first cycle of a new mode is dropped.
    assign entry     = (state != prev_state);
    assign chblk_evt = bus.i_chblk & ~chblk_d & ~entry;
    assign load_en   = (state == MODE_LOAD) && chblk_evt;
    assign out_en    = (state == MODE_OUT)  && chblk_evt;
    assign win_en    = (state == MODE_OUT)  && entry;

    mcu_ring_ptr #(.N(NB_BANK), .W(BW)) u_load_ptr (
        .clk    (clk),
        .rst    (rst),
        .en     (load_en),
        .step   ((BW+1)'(1)),
        .idx    (load_idx),
        .onehot (load_oh)
    );

    mcu_ring_ptr #(.N(NB_BANK), .W(BW)) u_out_ptr (
        .clk    (clk),
        .rst    (rst),
        .en     (out_en),
        .step   ((BW+1)'(1)),
        .idx    (out_idx),
        .onehot (unused_out_oh)
    );

    mcu_ring_ptr #(.N(NB_BANK), .W(BW)) u_win_ptr (
        .clk    (clk),
        .rst    (rst),
        .en     (win_en),
        .step   ((BW+1)'(STRIDE)),
        .idx    (win_base),
        .onehot (unused_win_oh)
    );

    // Register stage: mode, edge detector, counters and error flag.
    // During reset chblk_d captures the live strobe level, so a strobe held
    // high through reset is not mistaken for a fresh edge afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= MODE_LOAD;
            prev_state <= MODE_LOAD;
            chblk_d    <= bus.i_chblk;
            substate   <= '0;
            blk_cnt    <= '0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            prev_state <= state;
            chblk_d    <= bus.i_chblk;
            if (state_nxt == MODE_ILLEGAL) err <= 1'b1;
            if (win_en) begin
                substate <= (substate == SW'(SUB - 1)) ? '0 : substate + 1'b1;
            end
            if ((state == MODE_PROC) && entry) begin
                blk_cnt <= '0;
            end else if (load_en && (blk_cnt != CW'(NB_BANK))) begin
                blk_cnt <= blk_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = mode_e'({bus.i_eop, bus.i_sop});
        we        = '0;
        mem_sel   = '0;
        case (state)
            MODE_LOAD: begin
                we      = load_oh;
                mem_sel = load_idx;
            end
            MODE_PROC: begin
                we      = proc_mask(win_base);
                mem_sel = win_base;
            end
            MODE_OUT: begin
                mem_sel = out_idx;
            end
            default: begin
            end
        endcase
    end

    assign bus.o_we       = we;
    assign bus.o_mem_sel  = mem_sel;
    assign bus.o_win_base = win_base;
    assign bus.o_state    = state;
    assign bus.o_substate = substate;
    assign bus.o_blk_cnt  = blk_cnt;
    assign bus.o_ready    = (blk_cnt >= CW'(NB_KER));
    assign bus.o_err      = err;

endmodule
